// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives program_counter next value, single-outstanding imem fetch, decode hand-off.
// Optional macro FETCH_MISALIGN_CHECK_EN turns misaligned redirects into traps with a misalign_err pulse.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  output logic        misalign_err
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DELIVER} state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic        mis_c;
  logic [31:0] tgt_c;
  logic        trap_c;
  logic        redir_c;
  logic        flush_c;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign mis_c = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign tgt_c = redirect_target;
`else
  logic unused_lsb_c;
  assign unused_lsb_c = ^redirect_target[1:0];
  assign mis_c        = 1'b0;
  assign tgt_c        = {redirect_target[31:2], 2'b00};
`endif

  // A misaligned redirect behaves exactly like a trap.
  assign trap_c  = trap || mis_c;
  assign redir_c = redirect_valid && !trap_c;
  assign flush_c = trap_c || redir_c;

  // Next-state, PC steering and request generation.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    pc_next    = pc_in;
    imem_req   = 1'b0;
    imem_addr  = 32'h0;

    case (state_q)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_d = REQ;
      end
      REQ: begin
        imem_req = !stall && !trap && !redirect_valid;
        if (imem_req) begin
          imem_addr = pc_in;
        end
        if (imem_req && imem_gnt) begin
          pc_next  = pc_in + 32'd4;
          req_pc_d = pc_in;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // A response arriving together with a flush already belongs to the dead path.
        if (flush_c && imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = REQ;
        end else if (flush_c) begin
          kill_d = 1'b1;
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = req_pc_q;
            valid_d    = 1'b1;
            state_d    = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (flush_c || instr_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    if (state_q != BOOT) begin
      if (trap_c) begin
        pc_next = TRAP_VECTOR;
      end else if (redir_c) begin
        pc_next = tgt_c;
      end
      misalign_d = mis_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      kill_q     <= 1'b0;
      req_pc_q   <= 32'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_pc_q   <= req_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a small register stands in for program_counter.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        misalign_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_in <= 32'h0;
    else      pc_in <= pc_next;
  end

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap(trap), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; trap = 1'b0;
    #2;
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);

    tick(); rst = 1'b1;
    // BOOT -> REQ, first fetch at 0
    tick(); imem_gnt = 1'b1; #1;
    chk("req0", 32'(imem_req), 32'h1);
    chk("addr0", imem_addr, 32'h0);
    chk("pcn0", pc_next, 32'h4);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000; #1;
    chk("wait_req", 32'(imem_req), 32'h0);
    chk("wait_pcn", pc_next, 32'h4);
    tick(); imem_rvalid = 1'b0; #1;
    chk("dlv0_valid", 32'(instr_valid), 32'h1);
    chk("dlv0_instr", instr, 32'hA000_0000);
    chk("dlv0_pc", instr_pc, 32'h0);
    tick(); imem_gnt = 1'b1; #1;
    chk("req4_valid", 32'(instr_valid), 32'h0);
    chk("req4", 32'(imem_req), 32'h1);
    chk("addr4", imem_addr, 32'h4);

    // redirect to 0x200 while waiting for 0x4
    tick(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200; #1;
    chk("redir_pcn", pc_next, 32'h200);
    tick(); redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB000_0004; #1;
    chk("redir_pc_in", pc_in, 32'h200);
    tick(); imem_rvalid = 1'b0; #1;
    chk("kill_valid", 32'(instr_valid), 32'h0);
    chk("kill_req", 32'(imem_req), 32'h1);
    chk("kill_addr", imem_addr, 32'h200);

    // trap beats redirect in the same cycle
    trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300; #1;
    chk("trap_req", 32'(imem_req), 32'h0);
    chk("trap_pcn", pc_next, 32'h100);
    tick(); trap = 1'b0; redirect_valid = 1'b0; #1;
    chk("trap_addr", imem_addr, 32'h100);

    // stall for 5 cycles in REQ; stray rvalid is ignored
    stall = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_pcn", pc_next, 32'h100);
      tick();
    end
    stall = 1'b0; imem_rvalid = 1'b0; #1;
    chk("unstall_req", 32'(imem_req), 32'h1);
    chk("unstall_addr", imem_addr, 32'h100);
    chk("unstall_pcn", pc_next, 32'h104);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0100;
    tick(); imem_rvalid = 1'b0; instr_ready = 1'b0;

    // decode back-pressure for 4 cycles
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", 32'(instr_valid), 32'h1);
      chk("bp_instr", instr, 32'hC000_0100);
      chk("bp_pc", instr_pc, 32'h100);
      chk("bp_req", 32'(imem_req), 32'h0);
      tick();
    end
    instr_ready = 1'b1;
    tick(); instr_ready = 1'b0;

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0; imem_gnt = 1'b1; #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pcn", pc_next, 32'h0);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hD000_0000;
    tick(); imem_rvalid = 1'b0; #1;
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);

    // trap while holding an instruction drops it
    trap = 1'b1; #1;
    chk("trapd_pcn", pc_next, 32'h100);
    tick(); trap = 1'b0; #1;
    chk("trapd_valid", 32'(instr_valid), 32'h0);
    chk("trapd_addr", imem_addr, 32'h100);

    // misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h202; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_pcn", pc_next, 32'h100);
    tick(); redirect_valid = 1'b0; #1;
    chk("mis_pulse", 32'(misalign_err), 32'h1);
    chk("mis_addr", imem_addr, 32'h100);
    tick();
    chk("mis_clear", 32'(misalign_err), 32'h0);
`else
    chk("mis_pcn", pc_next, 32'h200);
    tick(); redirect_valid = 1'b0; #1;
    chk("mis_pulse", 32'(misalign_err), 32'h0);
    chk("mis_addr", imem_addr, 32'h200);
`endif

    // reset mid-operation while a request is outstanding
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; rst = 1'b0; #1;
    chk("mrst_pcn", pc_next, 32'h0);
    chk("mrst_req", 32'(imem_req), 32'h0);
    chk("mrst_valid", 32'(instr_valid), 32'h0);
    chk("mrst_instr", instr, 32'h0);
    tick(); rst = 1'b1;
    tick(); imem_rvalid = 1'b0; #1;
    chk("mrst_boot_req", 32'(imem_req), 32'h1);
    chk("mrst_boot_addr", imem_addr, 32'h0);
    chk("mrst_boot_valid", 32'(instr_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the program counter and instruction fetch for the RISC-V core. It drives the program counter's next-value input every cycle and issues single-outstanding requests to instruction memory. It hands fetched instructions to decode over a valid/ready handshake and applies stall, branch/jump redirect and trap redirect with fixed priority. It sits between `program_counter`, the instruction memory port and the decode stage.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset
- `TRAP_VECTOR`, 32'h0000_0100, fetch address on trap or misaligned redirect
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `pc_in` in 32: current PC (program_counter `data_out`)
- `pc_next` out 32: next PC (program_counter `data_in`), loaded every clock
- `imem_req` out 1: fetch request; `imem_addr` out 32: fetch address
- `imem_gnt` in 1: memory accepts request this cycle
- `imem_rvalid` in 1: response valid; `imem_rdata` in 32: response word
- `instr_valid` out 1, `instr` out 32, `instr_pc` out 32: to decode
- `instr_ready` in 1: decode accepts
- `stall` in 1: hold PC, suppress new requests
- `redirect_valid` in 1, `redirect_target` in 32: branch/jump redirect
- `trap` in 1: exception, redirect to `TRAP_VECTOR`
- `misalign_err` out 1: one-cycle pulse on misaligned redirect

## Operation
- FSM states: BOOT, REQ, WAIT, DELIVER. Reset state BOOT.
- BOOT: `pc_next`=RESET_VECTOR, no request; next state REQ.
- REQ: `imem_req` = !stall && !trap && !redirect_valid; `imem_addr`=`pc_in` when `imem_req`, else 0. Grant latches `req_pc`=`pc_in`, `pc_next`=`pc_in`+4 (mod 2^32), goes to WAIT. No grant: `pc_next`=`pc_in`.
- WAIT: no request; `pc_next`=`pc_in`. On `imem_rvalid`: if kill flag set, discard word, clear kill, go REQ; else register `instr`=`imem_rdata`, `instr_pc`=`req_pc`, set `instr_valid`, go DELIVER.
- DELIVER: `instr_valid` held with stable `instr`/`instr_pc` until `instr_ready`; on handshake clear `instr_valid`, go REQ.
- Priority per cycle: trap > redirect_valid > stall > sequential.
- Trap or redirect in any non-BOOT state: `pc_next`=TRAP_VECTOR or `redirect_target`; in WAIT set kill flag (stay WAIT); in DELIVER drop `instr_valid` next edge, go REQ; in REQ stay REQ.
- `stall` affects only REQ (request suppressed, PC held); response capture in WAIT and hand-off in DELIVER proceed.
- At most one outstanding request; `imem_rvalid` outside WAIT ignored.
- Reset mid-operation: all state, kill flag and outputs cleared immediately; pending memory response discarded.

## Timing
- Reset values: `pc_next`=RESET_VECTOR, `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `misalign_err`=0.
- `pc_next`, `imem_req`, `imem_addr` combinational from state and inputs; `instr*`, `misalign_err` registered.
- Grant to `instr_valid`: memory latency + 1 cycle. Zero-wait memory (`rvalid` the cycle after grant), `instr_ready` high: one instruction every 3 cycles.
- Redirect visible at `pc_in` one cycle after assertion; first request to target in that cycle if in REQ.
- PC wrap: `pc_in`=32'hFFFF_FFFC granted gives `pc_next`=0.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_target[1:0]`!=0 is treated as trap (`pc_next`=TRAP_VECTOR) and pulses `misalign_err` high for one cycle on the next edge.
- Undefined: `redirect_target[1:0]` forced to 2'b00, `misalign_err` tied 0.

## Test plan
- Reset release, RESET_VECTOR=0, zero-wait memory, ready high -> requests at 0x0, 0x4, 0x8 every 3 cycles; `instr_pc` matches.
- Redirect to 0x200 while in WAIT for 0x4 -> response for 0x4 discarded, no `instr_valid`, next request addr 0x200.
- `trap` and `redirect_valid` (0x300) same cycle -> next request addr 0x100; no request to 0x300.
- `stall` high 5 cycles in REQ -> `imem_req`=0, `pc_next`=`pc_in` throughout; request resumes cycle after stall drops.
- `instr_ready` low 4 cycles in DELIVER -> `instr`/`instr_pc` stable, no new request; PC=32'hFFFF_FFFC granted -> `pc_next`=0.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x202 -> `misalign_err` one-cycle pulse, next fetch 0x100; without it -> fetch 0x200, `misalign_err` stays 0.
